fetcher: RTL and testbench
==========================

FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst input 1 reset, synchronous, active-high; rdy input 1 global enable, low freezes all state.
REQ-002 SHALL have ports: mem_req output 1, fetch request held until accepted; mem_addr output 32, word-aligned fetch address; mem_done input 1, one-cycle pulse carrying mem_data; mem_data input 32, fetched word.
REQ-003 SHALL have ports: instr_ready output 1, instr_out valid to decoder; instr_out output 32; instr_addr_out output 32.
REQ-004 SHALL have ports: instr_issued input 1, decoder consumed instr_out; predict_pc input 32, next pc, valid when instr_issued=1.
REQ-005 SHALL have ports: rob_clear input 1, mispredict flush; rob_clear_pc input 32, redirect target.

Function
REQ-006 SHALL implement states IDLE (issue fetch), WAIT_MEM (await mem_done), HOLD (instruction presented), DRAIN (discard in-flight response).
REQ-007 SHALL hold pc register; mem_addr = pc; mem_req = 1 exactly in IDLE (cache miss or cache disabled) and WAIT_MEM.
REQ-008 SHALL, in WAIT_MEM on mem_done, latch mem_data into instr_out, pc into instr_addr_out, enter HOLD next cycle.
REQ-009 SHALL drive instr_ready = (state==HOLD) && !instr_issued, combinationally, so a one-cycle instr_issued pulse never causes double issue.
REQ-010 SHALL, in HOLD with instr_issued=1, load pc <= predict_pc and enter IDLE; instr_out/instr_addr_out unchanged until next fill.
REQ-011 SHALL treat rob_clear as highest priority: pc <= rob_clear_pc; from IDLE/HOLD go IDLE; from WAIT_MEM go DRAIN unless mem_done same cycle (then IDLE, data dropped).
REQ-012 SHALL, in DRAIN, keep mem_req=0, discard the response on mem_done, then enter IDLE; a further rob_clear in DRAIN only updates pc.
REQ-013 SHALL ignore instr_issued while not in HOLD; rob_clear and instr_issued simultaneous -> rob_clear wins.
REQ-014 SHALL force pc low two bits to 0 on every load; pc arithmetic 32-bit wrap-around.
REQ-015 SHALL, when rdy=0, hold every register and keep outputs stable.

Reset
REQ-016 SHALL on rst: state IDLE, pc 0, instr_out 0, instr_addr_out 0, instr_ready 0, mem_req 0 for that cycle; reset overrides rdy, abandons in-flight request with no DRAIN (memory controller is reset together).

Configuration
REQ-017 SHALL, with ICACHE_EN defined, include direct-mapped instruction cache: ICACHE_LINES=16 one-word lines, index pc[5:2], tag pc[31:6], valid bits cleared on rst only.
REQ-018 SHALL, with ICACHE_EN, on hit in IDLE: no mem_req, instr_out <= cached word, enter HOLD next cycle (1-cycle latency); fill on every mem_done in WAIT_MEM and DRAIN (address of the request).
REQ-019 SHALL, without ICACHE_EN, fetch every instruction from memory; no cache storage synthesized.

Structure
REQ-020 SHALL place state encodings, ICACHE_LINES, ICACHE_INDEX_WIDTH in shared config.v.
REQ-021 SHALL implement cache as sub-module icache (lookup: addr -> hit, data; fill: we, addr, data), instantiated only under ICACHE_EN.

Verification
REQ-022 Reset, mem returns 0x00000013 at addr 0 after 3 cycles -> mem_addr 0, instr_ready 1 with instr_out 0x00000013, instr_addr_out 0.
REQ-023 HOLD, instr_issued=1 with predict_pc 0x00000010 -> instr_ready 0 same cycle, next mem_addr 0x10, no second issue of old word.
REQ-024 WAIT_MEM at pc 0x8, rob_clear with rob_clear_pc 0x40 -> DRAIN, response for 0x8 discarded, next mem_addr 0x40, instr_addr_out 0x40.
REQ-025 rob_clear and instr_issued same cycle in HOLD, predict_pc 0x20, rob_clear_pc 0x80 -> next fetch 0x80.
REQ-026 ICACHE_EN: fetch 0x4, later refetch 0x4 -> second fetch mem_req never asserted, instr_ready one cycle after IDLE; 0x44 (same index) -> miss, memory fetch, line replaced.
REQ-027 rdy=0 for 5 cycles during WAIT_MEM -> state, mem_addr, outputs unchanged; resumes correctly when rdy=1.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared configuration for the instruction fetcher.
//   state_t             - fetch FSM states (IDLE/WAIT_MEM/HOLD/DRAIN)
//   ICACHE_LINES        - number of one-word lines in the optional icache
//   ICACHE_INDEX_WIDTH  - log2(ICACHE_LINES), index taken from pc[5:2]
//   ICACHE_TAG_WIDTH    - remaining upper word-address bits, pc[31:6]
//   word_align()        - clears the two byte-offset bits of an address
package fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // issue a fetch for pc (or hit in the icache)
    ST_WAIT_MEM = 2'd1,  // request outstanding, waiting for mem_done
    ST_HOLD     = 2'd2,  // instruction presented to the decoder
    ST_DRAIN    = 2'd3   // flushed while a response is still in flight
  } state_t;

  localparam int ICACHE_LINES       = 16;
  localparam int ICACHE_INDEX_WIDTH = 4;
  localparam int ICACHE_TAG_WIDTH   = 30 - ICACHE_INDEX_WIDTH;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
//   clk, rst     - clock, synchronous active-high reset (clears valid bits)
//   lookup_word  - word address (addr[31:2]) being looked up
//   hit          - lookup_word is resident
//   hit_data     - cached word for lookup_word (meaningful only when hit)
//   fill_we      - write fill_data into the line selected by fill_word
//   fill_word    - word address (addr[31:2]) of the returned fetch
//   fill_data    - word returned by memory
module icache
  import fetcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_word,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill_we,
  input  logic [29:0] fill_word,
  input  logic [31:0] fill_data
);

  logic [ICACHE_LINES-1:0] valid;
  logic [ICACHE_TAG_WIDTH-1:0] tag_mem [ICACHE_LINES];
  logic [31:0]                 data_mem [ICACHE_LINES];

  logic [ICACHE_INDEX_WIDTH-1:0] lookup_idx, fill_idx;
  logic [ICACHE_TAG_WIDTH-1:0]   lookup_tag, fill_tag;

  assign lookup_idx = lookup_word[ICACHE_INDEX_WIDTH-1:0];
  assign lookup_tag = lookup_word[29:ICACHE_INDEX_WIDTH];
  assign fill_idx   = fill_word[ICACHE_INDEX_WIDTH-1:0];
  assign fill_tag   = fill_word[29:ICACHE_INDEX_WIDTH];

  assign hit      = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
  assign hit_data = data_mem[lookup_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_we) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; a line is unusable until its valid
  // bit is set, so resetting the storage would only add logic.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: fetches the word at pc, presents it to the decoder,
// follows predicted next-pc on issue and redirects on a ROB flush.
// Optional feature macro: ICACHE_EN (adds a 16-line direct-mapped icache).
//   clk, rst        - clock, synchronous active-high reset
//   rdy             - global enable; low freezes every register
//   mem_req/addr    - fetch request (held until response) and word address
//   mem_done/data   - one-cycle response pulse and fetched word
//   instr_ready     - instr_out/instr_addr_out valid to the decoder
//   instr_issued    - decoder consumed the word; predict_pc is the next pc
//   rob_clear(_pc)  - mispredict flush and redirect target
module fetcher
  import fetcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc
);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        load_instr;
  logic [31:0] load_data;
  logic        idle_hit;

`ifdef ICACHE_EN
  logic [31:0] req_addr;   // address of the outstanding request (fill target)
  logic        hit;
  logic [31:0] hit_data;
  logic        fill_we;

  // Every response fills, including one being drained after a flush.
  assign fill_we = !rst && rdy && mem_done &&
                   ((state == ST_WAIT_MEM) || (state == ST_DRAIN));

  icache u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (pc[31:2]),
    .hit         (hit),
    .hit_data    (hit_data),
    .fill_we     (fill_we),
    .fill_word   (req_addr[31:2]),
    .fill_data   (mem_data)
  );

  assign idle_hit = hit;
`else
  assign idle_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_instr = 1'b0;
    load_data  = mem_data;
    case (state)
      ST_IDLE: begin
        if (rob_clear) begin
          pc_next = word_align(rob_clear_pc);
        end else if (idle_hit) begin
          load_instr = 1'b1;
`ifdef ICACHE_EN
          load_data  = hit_data;
`endif
          state_next = ST_HOLD;
        end else begin
          state_next = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (rob_clear) begin
          pc_next    = word_align(rob_clear_pc);
          // A response arriving with the flush is simply dropped.
          state_next = mem_done ? ST_IDLE : ST_DRAIN;
        end else if (mem_done) begin
          load_instr = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rob_clear) begin
          pc_next    = word_align(rob_clear_pc);
          state_next = ST_IDLE;
        end else if (instr_issued) begin
          pc_next    = word_align(predict_pc);
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (rob_clear) pc_next = word_align(rob_clear_pc);
        if (mem_done)  state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pc             <= '0;
      instr_out      <= '0;
      instr_addr_out <= '0;
    end else if (rdy) begin
      state <= state_next;
      pc    <= pc_next;
      if (load_instr) begin
        instr_out      <= load_data;
        instr_addr_out <= pc;
      end
    end
  end

`ifdef ICACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= '0;
    end else if (rdy && (state == ST_IDLE)) begin
      req_addr <= pc;
    end
  end
`endif

  assign mem_addr = pc;

  // Both strobes are forced low during reset since state may still be stale.
  assign mem_req = !rst && (((state == ST_IDLE) && !idle_hit) ||
                            (state == ST_WAIT_MEM));

  // Dropping ready in the issue cycle itself prevents a second issue.
  assign instr_ready = !rst && (state == ST_HOLD) && !instr_issued;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: a directed cycle table, an icache
// sequence (when ICACHE_EN is defined) and a randomized run against a
// pc-stream reference model with a latency-randomized memory model.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        mem_req, mem_done;
  logic [31:0] mem_addr, mem_data;
  logic        instr_ready, instr_issued, rob_clear;
  logic [31:0] instr_out, instr_addr_out, predict_pc, rob_clear_pc;

  fetcher dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_done       (mem_done),
    .mem_data       (mem_data),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_addr_out (instr_addr_out),
    .instr_issued   (instr_issued),
    .predict_pc     (predict_pc),
    .rob_clear      (rob_clear),
    .rob_clear_pc   (rob_clear_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address, with word 0 = 0x13.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- memory model (active when auto_mem) ----------------
  bit          auto_mem = 1'b0;
  bit          busy     = 1'b0;
  int          lat_cnt  = 0;
  logic [31:0] req_a    = '0;

  // Advance one clock; the memory model sees the inputs/outputs as they
  // were just before the edge and, like the fetcher, stalls when rdy=0.
  task automatic step();
    logic p_rst, p_rdy, p_req, p_done;
    logic [31:0] p_addr;
    #1;
    p_rst = rst; p_rdy = rdy; p_req = mem_req; p_done = mem_done; p_addr = mem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (p_rst) begin
        busy = 1'b0; mem_done = 1'b0;
      end else if (p_rdy) begin
        if (p_done) begin
          busy = 1'b0; mem_done = 1'b0;
        end else if (!busy && p_req) begin
          busy = 1'b1; req_a = p_addr; lat_cnt = $urandom_range(1, 4);
        end
        if (busy && !mem_done) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            mem_done = 1'b1; mem_data = mem_word(req_a);
          end
        end
        if (!mem_done) mem_data = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_data = '0;
    instr_issued = 1'b0; rob_clear = 1'b0; predict_pc = '0; rob_clear_pc = '0;
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_instr_ready", instr_ready, 0);
    step();
    check("rst_mem_req2", mem_req, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_addr_out", instr_addr_out, 0);
    rst = 1'b0;
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rdy, done;
    logic [31:0] data;
    logic        iss;
    logic [31:0] ppc;
    logic        rc;
    logic [31:0] rcp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ready;
    logic [31:0] e_iout, e_iaddr;
  } vec_t;

  function automatic vec_t v(input logic r, input logic d, input logic [31:0] dat,
                             input logic is, input logic [31:0] pp,
                             input logic c, input logic [31:0] cp,
                             input logic er, input logic [31:0] ea,
                             input logic ey, input logic [31:0] eo,
                             input logic [31:0] ei);
    vec_t t;
    t.rdy = r; t.done = d; t.data = dat; t.iss = is; t.ppc = pp; t.rc = c; t.rcp = cp;
    t.e_req = er; t.e_addr = ea; t.e_ready = ey; t.e_iout = eo; t.e_iaddr = ei;
    return t;
  endfunction

  localparam logic [31:0] D1 = 32'h1111_0010;
  localparam logic [31:0] D2 = 32'h2222_0040;
  localparam logic [31:0] D3 = 32'h3333_00C4;

  vec_t vecs[29];

  task automatic run_table();
    //             rdy dn data          iss ppc      rc rcp      req addr    rdy iout   iaddr
    vecs[0]  = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h0,   0, 0,      0);
    vecs[1]  = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h0,   0, 0,      0);
    vecs[2]  = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h0,   0, 0,      0);
    vecs[3]  = v(1, 1, 32'h13,       0, 0,       0, 0,       1, 32'h0,   0, 0,      0);
    vecs[4]  = v(1, 0, 0,            0, 0,       0, 0,       0, 32'h0,   1, 32'h13, 0);
    vecs[5]  = v(1, 0, 0,            1, 32'h10,  0, 0,       0, 32'h0,   0, 32'h13, 0);
    vecs[6]  = v(1, 0, 0,            1, 32'h99,  0, 0,       1, 32'h10,  0, 32'h13, 0);
    vecs[7]  = v(1, 1, D1,           0, 0,       0, 0,       1, 32'h10,  0, 32'h13, 0);
    vecs[8]  = v(1, 0, 0,            1, 32'hB,   0, 0,       0, 32'h10,  0, D1,     32'h10);
    vecs[9]  = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h8,   0, D1,     32'h10);
    vecs[10] = v(1, 0, 0,            0, 0,       1, 32'h40,  1, 32'h8,   0, D1,     32'h10);
    vecs[11] = v(1, 0, 0,            0, 0,       0, 0,       0, 32'h40,  0, D1,     32'h10);
    vecs[12] = v(1, 1, 32'hDEAD0008, 0, 0,       0, 0,       0, 32'h40,  0, D1,     32'h10);
    vecs[13] = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h40,  0, D1,     32'h10);
    vecs[14] = v(0, 1, 32'hBAD00000, 1, 32'h200, 0, 0,       1, 32'h40,  0, D1,     32'h10);
    vecs[15] = v(0, 1, 32'hBAD00000, 0, 0,       1, 32'h300, 1, 32'h40,  0, D1,     32'h10);
    vecs[16] = v(0, 0, 0,            0, 0,       0, 0,       1, 32'h40,  0, D1,     32'h10);
    vecs[17] = v(0, 1, 32'hBAD00001, 1, 32'h204, 1, 32'h304, 1, 32'h40,  0, D1,     32'h10);
    vecs[18] = v(0, 0, 0,            0, 0,       0, 0,       1, 32'h40,  0, D1,     32'h10);
    vecs[19] = v(1, 1, D2,           0, 0,       0, 0,       1, 32'h40,  0, D1,     32'h10);
    vecs[20] = v(1, 0, 0,            0, 0,       0, 0,       0, 32'h40,  1, D2,     32'h40);
    vecs[21] = v(1, 0, 0,            1, 32'h20,  1, 32'h80,  0, 32'h40,  0, D2,     32'h40);
    vecs[22] = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h80,  0, D2,     32'h40);
    vecs[23] = v(1, 1, 32'h55550080, 0, 0,       1, 32'hC4,  1, 32'h80,  0, D2,     32'h40);
    vecs[24] = v(1, 0, 0,            0, 0,       0, 0,       1, 32'hC4,  0, D2,     32'h40);
    vecs[25] = v(1, 1, D3,           0, 0,       0, 0,       1, 32'hC4,  0, D2,     32'h40);
    vecs[26] = v(1, 0, 0,            0, 0,       0, 0,       0, 32'hC4,  1, D3,     32'hC4);
    vecs[27] = v(1, 0, 0,            0, 0,       1, 32'h101, 0, 32'hC4,  1, D3,     32'hC4);
    vecs[28] = v(1, 0, 0,            0, 0,       0, 0,       1, 32'h100, 0, D3,     32'hC4);
    auto_mem = 1'b0;
    do_reset();
    for (int i = 0; i < 29; i++) begin
      rdy = vecs[i].rdy; mem_done = vecs[i].done; mem_data = vecs[i].data;
      instr_issued = vecs[i].iss; predict_pc = vecs[i].ppc;
      rob_clear = vecs[i].rc; rob_clear_pc = vecs[i].rcp;
      #1;
      check($sformatf("vec%0d_mem_req", i),        mem_req,        vecs[i].e_req);
      check($sformatf("vec%0d_mem_addr", i),       mem_addr,       vecs[i].e_addr);
      check($sformatf("vec%0d_instr_ready", i),    instr_ready,    vecs[i].e_ready);
      check($sformatf("vec%0d_instr_out", i),      instr_out,      vecs[i].e_iout);
      check($sformatf("vec%0d_instr_addr_out", i), instr_addr_out, vecs[i].e_iaddr);
      step();
    end
    rdy = 1'b1; mem_done = 1'b0; instr_issued = 1'b0; rob_clear = 1'b0;
  endtask

  // Wait (bounded) for instr_ready; reports cycles waited and whether a
  // memory request was seen meanwhile.
  task automatic wait_ready(input string name, output int cycles, output bit saw_req);
    cycles = 0;
    #1;
    saw_req = mem_req;
    while (!instr_ready && cycles < 60) begin
      step();
      #1;
      saw_req = saw_req | mem_req;
      cycles++;
    end
    check({name, "_ready_timeout"}, instr_ready, 1);
  endtask

`ifdef ICACHE_EN
  // Called in a cycle where instr_ready=1: issue with predict_pc=a and
  // check how the next word arrives.
  task automatic fetch_next(input logic [31:0] a, input bit exp_hit, input string name);
    int cyc;
    bit saw;
    instr_issued = 1'b1; predict_pc = a;
    step();
    instr_issued = 1'b0;
    wait_ready(name, cyc, saw);
    check({name, "_mem_req_seen"}, saw, !exp_hit);
    if (exp_hit) check({name, "_hit_latency"}, cyc, 1);
    check({name, "_addr"}, instr_addr_out, a);
    check({name, "_data"}, instr_out, mem_word(a));
  endtask

  task automatic run_cache_seq();
    int cyc;
    bit saw;
    auto_mem = 1'b1;
    do_reset();
    wait_ready("c_first", cyc, saw);
    check("c_first_addr", instr_addr_out, 0);
    fetch_next(32'h4,  1'b0, "c_4_miss");
    fetch_next(32'h8,  1'b0, "c_8_miss");
    fetch_next(32'h4,  1'b1, "c_4_hit");
    fetch_next(32'h44, 1'b0, "c_44_miss");
    fetch_next(32'h4,  1'b0, "c_4_replaced");
    fetch_next(32'h44, 1'b0, "c_44_replaced");
    fetch_next(32'h8,  1'b1, "c_8_hit");
  endtask
`endif

  // ---------------- randomized run against pc-stream model ----------------
  logic [31:0] pool[8];

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
  endfunction

  task automatic run_random();
    logic [31:0] exp_pc;
    int presented = 0;
    pool[0] = 32'h0;  pool[1] = 32'h4;  pool[2] = 32'h8;  pool[3] = 32'h44;
    pool[4] = 32'h40; pool[5] = 32'h84; pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h1000;
    auto_mem = 1'b1;
    do_reset();
    exp_pc = '0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        do_reset();
        exp_pc = '0;
      end
      rdy = ($urandom_range(0, 7) != 0);
      instr_issued = 1'b0; rob_clear = 1'b0;
      predict_pc = pick(); rob_clear_pc = pick();
      #1;
      if (instr_ready) begin
        check("rnd_instr_addr_out", instr_addr_out, exp_pc);
        check("rnd_instr_out", instr_out, mem_word(exp_pc));
        presented++;
      end
      if (mem_req) check("rnd_mem_addr", mem_addr, exp_pc);
      if (rdy && instr_ready && $urandom_range(0, 1) == 1) instr_issued = 1'b1;
      // No flush in the cycle a fresh request is handed to memory.
      if (rdy && $urandom_range(0, 11) == 0 && !(mem_req && !busy)) rob_clear = 1'b1;
      if (instr_issued) begin
        #1;
        check("rnd_ready_drop", instr_ready, 0);
      end
      if (rdy) begin
        if (rob_clear)         exp_pc = rob_clear_pc & 32'hFFFF_FFFC;
        else if (instr_issued) exp_pc = predict_pc & 32'hFFFF_FFFC;
      end
      step();
    end
    total++;
    if (presented < 100) begin
      bad++;
      $display("FAIL rnd_progress: got %0d presentations required at least 100", presented);
    end
  endtask

  initial begin
    run_table();
`ifdef ICACHE_EN
    run_cache_seq();
`endif
    run_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
